// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler
//
// Purpose:
//   Owns every write into the 2-bit branch-history counter table (BHT) and
//   shares the table's single synchronous read port with fetch lookups.
//   ROB commit outcomes are buffered in a small FIFO. Each one is applied as
//   a read-modify-write saturating-counter update. After reset and on flush,
//   the whole table is walked and every entry is set to INIT_VAL.
//
// Ports:
//   clk_in               clock
//   rst_in               asynchronous active-low reset
//   rdy_in               global enable; low freezes all state
//   flush_in             re-initialise the table (drops queued updates)
//   rob_to_bp_ready      commit update valid
//   rob_to_bp_pc         PC of the committed branch
//   rob_to_bp_actual_br  actual outcome, 1 = taken
//   bp_to_rob_full       update FIFO full; ROB must hold its update
//   iu_lookup_valid      fetch owns the table read port this cycle
//   tbl_rd_en/idx        scheduler read request into the BHT
//   tbl_rd_data          BHT read data, valid the cycle after tbl_rd_en
//   tbl_wr_en/idx/data   BHT write port
//   busy_out             high while the table is being initialised
module bp_update_scheduler #(
  parameter int         BHT_WIDTH  = 6,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_VAL   = 2'b10
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 rob_to_bp_ready,
  input  logic [31:0]          rob_to_bp_pc,
  input  logic                 rob_to_bp_actual_br,
  output logic                 bp_to_rob_full,
  input  logic                 iu_lookup_valid,
  output logic                 tbl_rd_en,
  output logic [BHT_WIDTH-1:0] tbl_rd_idx,
  input  logic [1:0]           tbl_rd_data,
  output logic                 tbl_wr_en,
  output logic [BHT_WIDTH-1:0] tbl_wr_idx,
  output logic [1:0]           tbl_wr_data,
  output logic                 busy_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_RD   = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t               state_reg;
  logic [BHT_WIDTH-1:0] init_idx_reg;
  logic [BHT_WIDTH-1:0] upd_idx_reg;
  logic                 upd_taken_reg;
  logic [1:0]           old_ctr_reg;

  // Small FIFO of pending updates; read combinationally at the head.
  logic [BHT_WIDTH-1:0] fifo_idx_mem   [FIFO_DEPTH];
  logic                 fifo_taken_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;

  logic                 active;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 push;
  logic                 issue_rd;
  logic [BHT_WIDTH-1:0] push_idx;
  logic                 unused_pc_bits;

  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
    if (taken) begin
      return (c == 2'b11) ? 2'b11 : c + 2'b01;
    end
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  assign push_idx       = rob_to_bp_pc[BHT_WIDTH+1:2];
  assign unused_pc_bits = ^{rob_to_bp_pc[31:BHT_WIDTH+2], rob_to_bp_pc[1:0]};

  // rst_in is folded in so the enables drop the instant reset asserts,
  // not only after the state register has been cleared.
  assign active     = rst_in && rdy_in && !flush_in;
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));

  // A push while full is dropped even if a pop frees a slot this cycle.
  assign push     = rst_in && rdy_in && !flush_in && rob_to_bp_ready && !fifo_full;
  // Fetch always wins the read port.
  assign issue_rd = active && (state_reg == S_IDLE) && !fifo_empty && !iu_lookup_valid;

  assign bp_to_rob_full = fifo_full;
  assign busy_out       = (state_reg == S_INIT);
  assign tbl_rd_en      = issue_rd;
  assign tbl_rd_idx     = issue_rd ? fifo_idx_mem[rd_ptr_reg] : '0;

  always_comb begin
    tbl_wr_en   = 1'b0;
    tbl_wr_idx  = '0;
    tbl_wr_data = 2'b00;
    if (active) begin
      case (state_reg)
        S_INIT: begin
          tbl_wr_en   = 1'b1;
          tbl_wr_idx  = init_idx_reg;
          tbl_wr_data = INIT_VAL;
        end
        S_WB: begin
          tbl_wr_en   = 1'b1;
          tbl_wr_idx  = upd_idx_reg;
          tbl_wr_data = sat_update(old_ctr_reg, upd_taken_reg);
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_idx_mem[wr_ptr_reg]   <= push_idx;
      fifo_taken_mem[wr_ptr_reg] <= rob_to_bp_actual_br;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg     <= S_INIT;
      init_idx_reg  <= '0;
      upd_idx_reg   <= '0;
      upd_taken_reg <= 1'b0;
      old_ctr_reg   <= 2'b00;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        state_reg    <= S_INIT;
        init_idx_reg <= '0;
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        count_reg    <= '0;
      end else begin
        case (state_reg)
          S_INIT: begin
            init_idx_reg <= init_idx_reg + BHT_WIDTH'(1);
            if (init_idx_reg == {BHT_WIDTH{1'b1}}) begin
              state_reg <= S_IDLE;
            end
          end
          S_IDLE: begin
            if (issue_rd) begin
              upd_idx_reg   <= fifo_idx_mem[rd_ptr_reg];
              upd_taken_reg <= fifo_taken_mem[rd_ptr_reg];
              state_reg     <= S_RD;
            end
          end
          S_RD: begin
            old_ctr_reg <= tbl_rd_data;
            state_reg   <= S_WB;
          end
          default: begin
            state_reg <= S_IDLE;
          end
        endcase

        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        end
        if (issue_rd) begin
          rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
        if (push && !issue_rd) begin
          count_reg <= count_reg + CNT_W'(1);
        end else if (!push && issue_rd) begin
          count_reg <= count_reg - CNT_W'(1);
        end
      end
    end
  end

endmodule
